mips16_mc_control: RTL and testbench
====================================

# mips16_mc_control

Multi-cycle main control unit for the 16-bit MIPS core. Sequences each instruction through fetch, decode, execute, memory and write-back states over a shared ALU and a single unified memory port. Drives the 2-bit ALUOp consumed by the ALU control decoder, plus every datapath mux select and write strobe. Handles a variable-latency memory handshake.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: max cycles `mem_req` may wait for `mem_ready` before trap; 0 disables the timeout.

Ports (one clock, `clk`; reset `reset` is synchronous, active-high):
- `clk` in 1: core clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 4: `IR[15:12]` from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if `zero`.
- `ir_write` out 1: IR load.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: request is a write.
- `i_or_d` out 1: address select, 0 = PC, 1 = ALUOut.
- `reg_write` out 1: register file write.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `mem_to_reg` out 1: 0 = ALUOut, 1 = MDR.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 = B, 01 = const 1, 10 = sign-ext imm, 11 = sign-ext imm (branch offset).
- `alu_op` out 2: 00 = use Function, 01 = subtract, 10 = set-less-than, 11 = add.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `halted` out 1: in HALT.
- `illegal` out 1: in TRAP.
- `state` out 4: current state, debug only.

## Operation
- Opcodes:
  - 0000 R-type
  - 0001 lw
  - 0010 sw
  - 0011 beq
  - 0100 addi
  - 0101 slti
  - 0110 j
  - 1111 halt
  - all others are illegal.
- States and transitions:
  - IDLE(0) → FETCH.
  - FETCH waits until `mem_ready`, then → DECODE.
  - DECODE dispatches on opcode:
    - R-type → EXEC_R
    - lw/sw → MEM_ADDR
    - beq → BRANCH
    - addi/slti → EXEC_I
    - j → JUMP
    - halt → HALT
    - illegal → TRAP
  - EXEC_R → WB_R → FETCH.
  - EXEC_I → WB_I → FETCH.
  - MEM_ADDR → MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD waits for `mem_ready`, then → MEM_WB → FETCH.
  - MEM_WR waits for `mem_ready`, then → FETCH.
  - BRANCH → FETCH. JUMP → FETCH.
  - HALT and TRAP are absorbing; only `reset` exits them.
- Outputs per state (unlisted outputs are 0):
  - FETCH: `mem_req`, `i_or_d=0`, `alu_src_a=0`, `alu_src_b=01`, `alu_op=11`, `pc_source=00`.
  - DECODE: `alu_src_a=0`, `alu_src_b=11`, `alu_op=11` (precomputes branch target).
  - EXEC_R: `alu_src_a=1`, `alu_src_b=00`, `alu_op=00`.
  - EXEC_I: `alu_src_a=1`, `alu_src_b=10`; `alu_op=11` for addi, `10` for slti.
  - MEM_ADDR: `alu_src_a=1`, `alu_src_b=10`, `alu_op=11`.
  - MEM_RD: `mem_req`, `i_or_d=1`.
  - MEM_WR: `mem_req`, `mem_we`, `i_or_d=1`.
  - MEM_WB: `reg_write`, `mem_to_reg=1`, `reg_dst=0`.
  - WB_R: `reg_write`, `reg_dst=1`.
  - WB_I: `reg_write`, `reg_dst=0`.
  - BRANCH: `alu_src_a=1`, `alu_src_b=00`, `alu_op=01`, `pc_write_cond`, `pc_source=01`.
  - JUMP: `pc_write`, `pc_source=10`.
- Mealy strobes:
  - In FETCH, `ir_write` and `pc_write` equal `mem_ready`.
  - The opcode for EXEC_I/MEM_ADDR branching is sampled from IR, which is stable after FETCH.
- Timeout:
  - A wait-cycle counter runs in FETCH/MEM_RD/MEM_WR and clears on state change.
  - When it reaches `MEM_TIMEOUT` without `mem_ready`, → TRAP.

## Timing
- Reset:
  - Next edge forces IDLE and clears the counter.
  - In IDLE all outputs are 0, `state=0`, `halted=0`, `illegal=0`.
- `mem_req` rises the cycle after IDLE/after the prior state.
- `mem_req` holds, with address selects stable, until the cycle `mem_ready=1`.
- `mem_ready` while `mem_req=0` is ignored.
- Latency with zero-wait memory (`mem_ready` high in first request cycle):
  - R-type/addi/slti: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
- Each memory wait cycle adds 1.
- Reset mid-instruction: the in-flight access is abandoned and no further strobes are issued; reset dominates `mem_ready` in the same cycle.

## Structure
- Package `mips16_pkg`: opcode constants, state encoding, ALUOp constants (`ALUOP_FUNC`/`SUB`/`SLT`/`ADD`), `alu_src_b` and `pc_source` encodings.
- Sub-module `mips16_ctrl_decode`: purely combinational, maps state + opcode + `mem_ready` to outputs.
- Top module holds the state register, next-state logic and timeout counter.

## Test plan
- R-type, `mem_ready` tied 1: states 0→FETCH→DECODE→EXEC_R→WB_R→FETCH; `alu_op=00` in EXEC_R; `reg_write=1`, `reg_dst=1` exactly one cycle.
- lw with `mem_ready` low 3 cycles in MEM_RD: `mem_req`/`i_or_d=1` held 4 cycles; MEM_WB has `mem_to_reg=1`; total 8 cycles.
- beq with `zero=1`, then `zero=0`: BRANCH has `alu_op=01` and `pc_write_cond=1` in both cases; `pc_write=0` throughout BRANCH.
- opcode 1001 → TRAP, `illegal=1` stays set for 20 cycles until reset; opcode 1111 → `halted=1`, no `mem_req` afterwards.
- `MEM_TIMEOUT=4`, `mem_ready` held 0 in FETCH: TRAP entered after 4 wait cycles.
- Reset asserted in MEM_WR with `mem_ready=1` the same cycle: next state IDLE, all outputs 0, no `reg_write`/`pc_write` pulse.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared encodings for the multi-cycle MIPS16 control unit: opcodes, FSM states,
// ALUOp / mux-select codes and the bundle of control strobes.
package mips16_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_SLTI  = 4'b0101;
    localparam logic [3:0] OP_J     = 4'b0110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] ALUOP_FUNC = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_SLT  = 2'b10;
    localparam logic [1:0] ALUOP_ADD  = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_MEM_WB   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13,
        S_TRAP     = 4'd14
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    // States that hold a memory request open and may stall on mem_ready.
    function automatic logic is_mem_wait_state(state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mips16_mc_control_if.sv
// Control-unit <-> datapath/memory bundle. master = control unit, slave = datapath side.
interface mips16_mc_control_if;

    logic [3:0] opcode;
    logic       zero;
    // mem_req/mem_ready: a request stays asserted with stable address selects until
    // the cycle mem_ready is high, which completes it; mem_ready without mem_req is ignored.
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, ir_write, mem_req, mem_we, i_or_d,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               pc_source, halted, illegal, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, ir_write, mem_req, mem_we, i_or_d,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               pc_source, halted, illegal, state
    );

endinterface

// File: rtl/mips16_ctrl_decode.sv
// Combinational output decoder: state + opcode + mem_ready -> datapath strobes and selects.
module mips16_ctrl_decode
    import mips16_pkg::*;
(
    input  state_e     state_i,
    input  logic [3:0] opcode_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.alu_src_b = SRCB_ONE;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC+1 commit only in the cycle the fetch completes.
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_BOFF;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNC;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = (opcode_i == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.i_or_d  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.mem_we  = 1'b1;
                ctrl_o.i_or_d  = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_WB_R: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_WB_I: ctrl_o.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            S_HALT:  ctrl_o.halted  = 1'b1;
            S_TRAP:  ctrl_o.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips16_mc_control.sv
// Multi-cycle main control FSM: state register, next-state dispatch and the
// memory wait-cycle timeout that traps a stalled access.
module mips16_mc_control
    import mips16_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 reset,
    mips16_mc_control_if.master bus
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout;
    ctrl_t         ctrl;
    logic          unused_zero;

    // The zero flag gates pc_write_cond inside the datapath, not here.
    assign unused_zero = bus.zero;

    always_comb begin
        timeout = (MEM_TIMEOUT != 0) && !bus.mem_ready &&
                  (int'(wait_cnt_q) == MEM_TIMEOUT - 1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready)  state_d = S_DECODE;
                else if (timeout)   state_d = S_TRAP;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      state_d = S_EXEC_R;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_ADDI,
                    OP_SLTI:       state_d = S_EXEC_I;
                    OP_J:          state_d = S_JUMP;
                    OP_HALT:       state_d = S_HALT;
                    default:       state_d = S_TRAP;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_WB_R:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_WB_I;
            S_WB_I:     state_d = S_FETCH;
            S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.mem_ready)  state_d = S_MEM_WB;
                else if (timeout)   state_d = S_TRAP;
            end
            S_MEM_WR: begin
                if (bus.mem_ready)  state_d = S_FETCH;
                else if (timeout)   state_d = S_TRAP;
            end
            S_MEM_WB:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // Counts stalled cycles of the open request; any state change restarts it.
    always_comb begin
        wait_cnt_d = '0;
        if ((MEM_TIMEOUT != 0) && is_mem_wait_state(state_q) && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    mips16_ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (bus.opcode),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_req       = ctrl.mem_req;
    assign bus.mem_we        = ctrl.mem_we;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.halted        = ctrl.halted;
    assign bus.illegal       = ctrl.illegal;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_mips16_mc_control.sv
// Directed bench for mips16_mc_control: per-cycle expected outputs are queued by the
// driver and checked by an independent negedge monitor.
module tb_mips16_mc_control;

    logic clk;
    logic reset;

    mips16_mc_control_if bus_if ();

    mips16_mc_control #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    localparam logic [3:0] OP_R = 4'b0000, OP_LW = 4'b0001, OP_SW = 4'b0010, OP_BEQ = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100, OP_SLTI = 4'b0101, OP_J = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b1111, OP_BAD = 4'b1001;

    logic [21:0] exp_q[$];
    string       name_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [21:0] mon_exp, mon_act;
    string       mon_name;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {state, pc_write, pc_write_cond, ir_write, mem_req, mem_we, i_or_d, reg_write,
    //  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, halted, illegal}
    function automatic logic [21:0] ex(input int st, input logic pcw, pcwc, irw, mreq, mwe,
                                       iord, rw, rdst, m2r, srca, input logic [1:0] srcb,
                                       aop, psrc, input logic h, il);
        return {4'(st), pcw, pcwc, irw, mreq, mwe, iord, rw, rdst, m2r, srca,
                srcb, aop, psrc, h, il};
    endfunction

    function automatic logic [21:0] e_idle();      return ex(0,  0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0); endfunction
    function automatic logic [21:0] e_fetch(input logic mr);
                                                   return ex(1,  mr,0,mr,1,0,0,0,0,0,0, 2'b01,2'b11,2'b00, 0,0); endfunction
    function automatic logic [21:0] e_decode();    return ex(2,  0,0,0,0,0,0,0,0,0,0, 2'b11,2'b11,2'b00, 0,0); endfunction
    function automatic logic [21:0] e_exec_r();    return ex(3,  0,0,0,0,0,0,0,0,0,1, 2'b00,2'b00,2'b00, 0,0); endfunction
    function automatic logic [21:0] e_wb_r();      return ex(4,  0,0,0,0,0,0,1,1,0,0, 2'b00,2'b00,2'b00, 0,0); endfunction
    function automatic logic [21:0] e_exec_i(input logic [1:0] aop);
                                                   return ex(5,  0,0,0,0,0,0,0,0,0,1, 2'b10,aop,  2'b00, 0,0); endfunction
    function automatic logic [21:0] e_wb_i();      return ex(6,  0,0,0,0,0,0,1,0,0,0, 2'b00,2'b00,2'b00, 0,0); endfunction
    function automatic logic [21:0] e_mem_addr();  return ex(7,  0,0,0,0,0,0,0,0,0,1, 2'b10,2'b11,2'b00, 0,0); endfunction
    function automatic logic [21:0] e_mem_rd();    return ex(8,  0,0,0,1,0,1,0,0,0,0, 2'b00,2'b00,2'b00, 0,0); endfunction
    function automatic logic [21:0] e_mem_wr();    return ex(9,  0,0,0,1,1,1,0,0,0,0, 2'b00,2'b00,2'b00, 0,0); endfunction
    function automatic logic [21:0] e_mem_wb();    return ex(10, 0,0,0,0,0,0,1,0,1,0, 2'b00,2'b00,2'b00, 0,0); endfunction
    function automatic logic [21:0] e_branch();    return ex(11, 0,1,0,0,0,0,0,0,0,1, 2'b00,2'b01,2'b01, 0,0); endfunction
    function automatic logic [21:0] e_jump();      return ex(12, 1,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b10, 0,0); endfunction
    function automatic logic [21:0] e_halt();      return ex(13, 0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,0); endfunction
    function automatic logic [21:0] e_trap();      return ex(14, 0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,1); endfunction

    // One cycle: drive inputs just after the edge and queue what that cycle must show.
    task automatic step(input logic rst, input logic [3:0] op, input logic z, input logic mr,
                        input logic chk, input logic [21:0] e, input string nm);
        @(posedge clk);
        #1;
        reset            = rst;
        bus_if.opcode    = op;
        bus_if.zero      = z;
        bus_if.mem_ready = mr;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {bus_if.state, bus_if.pc_write, bus_if.pc_write_cond, bus_if.ir_write,
                        bus_if.mem_req, bus_if.mem_we, bus_if.i_or_d, bus_if.reg_write,
                        bus_if.reg_dst, bus_if.mem_to_reg, bus_if.alu_src_a, bus_if.alu_src_b,
                        bus_if.alu_op, bus_if.pc_source, bus_if.halted, bus_if.illegal};
            n_tests++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (t=%0t)", mon_name, mon_act, mon_exp, $time);
            end
        end
    end

    initial begin
        reset            = 1'b1;
        bus_if.opcode    = 4'b0000;
        bus_if.zero      = 1'b0;
        bus_if.mem_ready = 1'b0;

        step(1, OP_R, 0, 0, 0, e_idle(), "pre_reset");
        step(1, OP_R, 0, 1, 1, e_idle(), "reset_idle");
        step(0, OP_R, 0, 1, 1, e_idle(), "idle");

        // R-type, zero-wait memory
        step(0, OP_R, 0, 1, 1, e_fetch(1), "r_fetch");
        step(0, OP_R, 0, 1, 1, e_decode(), "r_decode");
        step(0, OP_R, 0, 1, 1, e_exec_r(), "r_exec");
        step(0, OP_R, 0, 1, 1, e_wb_r(),   "r_wb");

        // lw with three wait cycles in MEM_RD
        step(0, OP_LW, 0, 1, 1, e_fetch(1),   "lw_fetch");
        step(0, OP_LW, 0, 1, 1, e_decode(),   "lw_decode");
        step(0, OP_LW, 0, 1, 1, e_mem_addr(), "lw_addr");
        for (int i = 0; i < 3; i++) step(0, OP_LW, 0, 0, 1, e_mem_rd(), "lw_rd_wait");
        step(0, OP_LW, 0, 1, 1, e_mem_rd(), "lw_rd_done");
        step(0, OP_LW, 0, 1, 1, e_mem_wb(), "lw_wb");

        // sw
        step(0, OP_SW, 0, 1, 1, e_fetch(1),   "sw_fetch");
        step(0, OP_SW, 0, 1, 1, e_decode(),   "sw_decode");
        step(0, OP_SW, 0, 1, 1, e_mem_addr(), "sw_addr");
        step(0, OP_SW, 0, 1, 1, e_mem_wr(),   "sw_wr");

        // addi then slti
        step(0, OP_ADDI, 0, 1, 1, e_fetch(1),      "addi_fetch");
        step(0, OP_ADDI, 0, 1, 1, e_decode(),      "addi_decode");
        step(0, OP_ADDI, 0, 1, 1, e_exec_i(2'b11), "addi_exec");
        step(0, OP_ADDI, 0, 1, 1, e_wb_i(),        "addi_wb");
        step(0, OP_SLTI, 0, 1, 1, e_fetch(1),      "slti_fetch");
        step(0, OP_SLTI, 0, 1, 1, e_decode(),      "slti_decode");
        step(0, OP_SLTI, 0, 1, 1, e_exec_i(2'b10), "slti_exec");
        step(0, OP_SLTI, 0, 1, 1, e_wb_i(),        "slti_wb");

        // beq taken / not taken: identical control in BRANCH
        step(0, OP_BEQ, 1, 1, 1, e_fetch(1), "beq1_fetch");
        step(0, OP_BEQ, 1, 1, 1, e_decode(), "beq1_decode");
        step(0, OP_BEQ, 1, 1, 1, e_branch(), "beq1_branch");
        step(0, OP_BEQ, 0, 1, 1, e_fetch(1), "beq0_fetch");
        step(0, OP_BEQ, 0, 1, 1, e_decode(), "beq0_decode");
        step(0, OP_BEQ, 0, 1, 1, e_branch(), "beq0_branch");

        // j
        step(0, OP_J, 0, 1, 1, e_fetch(1), "j_fetch");
        step(0, OP_J, 0, 1, 1, e_decode(), "j_decode");
        step(0, OP_J, 0, 1, 1, e_jump(),   "j_jump");

        // one fetch stall, then illegal opcode traps until reset
        step(0, OP_BAD, 0, 0, 1, e_fetch(0), "bad_fetch_wait");
        step(0, OP_BAD, 0, 1, 1, e_fetch(1), "bad_fetch");
        step(0, OP_BAD, 0, 1, 1, e_decode(), "bad_decode");
        for (int i = 0; i < 20; i++) step(0, OP_BAD, 0, 1'(i % 2), 1, e_trap(), "trap_hold");
        step(1, OP_BAD, 0, 1, 1, e_trap(), "trap_reset_cycle");
        step(0, OP_HALT, 0, 1, 1, e_idle(), "trap_exit_idle");

        // halt is absorbing, no further requests
        step(0, OP_HALT, 0, 1, 1, e_fetch(1), "halt_fetch");
        step(0, OP_HALT, 0, 1, 1, e_decode(), "halt_decode");
        for (int i = 0; i < 10; i++) step(0, OP_HALT, 0, 1, 1, e_halt(), "halt_hold");
        step(1, OP_HALT, 0, 1, 1, e_halt(), "halt_reset_cycle");
        step(0, OP_R, 0, 0, 1, e_idle(), "halt_exit_idle");

        // fetch timeout: four stalled cycles, then TRAP
        for (int i = 0; i < 4; i++) step(0, OP_R, 0, 0, 1, e_fetch(0), "to_fetch_wait");
        step(0, OP_R, 0, 0, 1, e_trap(), "to_trap");
        step(0, OP_R, 0, 1, 1, e_trap(), "to_trap_hold");
        step(1, OP_R, 0, 0, 1, e_trap(), "to_reset_cycle");

        // reset in MEM_WR with mem_ready high the same cycle
        step(0, OP_SW, 0, 1, 1, e_idle(),     "rst_wr_idle");
        step(0, OP_SW, 0, 1, 1, e_fetch(1),   "rst_wr_fetch");
        step(0, OP_SW, 0, 1, 1, e_decode(),   "rst_wr_decode");
        step(0, OP_SW, 0, 1, 1, e_mem_addr(), "rst_wr_addr");
        step(1, OP_SW, 0, 1, 1, e_mem_wr(),   "rst_wr_memwr");
        step(0, OP_SW, 0, 1, 1, e_idle(),     "rst_wr_after");
        step(0, OP_SW, 0, 1, 1, e_fetch(1),   "rst_wr_refetch");

        @(posedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
